fpu_issue_ctrl: RTL
===================

// Module: fpu_issue_ctrl
// PURPOSE
//  Sequencer between the core FP pipeline and fpu_arithmetic_top.
//  - Accepts one FP request at a time over a valid/ready handshake and registers its operands.
//  - Drives start/op/rm/A/B and holds them stable until done; captures the result and exception flags.
//  - Returns the result over a valid/ready handshake.
//  - Owns the architectural fflags/frm CSR state, with a watchdog and flush.
// PARAMETERS
//  TAG_W    5   width of the destination tag passed through unchanged
//  TIMEOUT  64  max EXEC cycles without done before abort (>=2)
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-low reset
//  flush          in   1      abandon in-flight/pending op
//  req_valid      in   1      request present
//  req_ready      out  1      controller can accept
//  req_op         in   5      FPU op code (fpu_arithmetic_top encoding)
//  req_rm         in   3      instruction rm/funct3 field
//  req_rs2_lsb    in   1      signed/unsigned select for cvt
//  req_a, req_b   in   32     operands
//  req_tag        in   TAG_W  destination tag
//  fpu_start      out  1      to fpu_arithmetic_top.start
//  fpu_op         out  5      to .op
//  fpu_rm         out  3      to .rounding_mode
//  fpu_frm        out  3      to .csr_dynamic_rounding_mode (= frm register)
//  fpu_a, fpu_b   out  32     to .A/.B
//  fpu_rs2_lsb    out  1      to .rs2_lsb
//  fpu_out        in   32     from .fpu_arith_out
//  fpu_done       in   1      from .done
//  fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx  in 1 each  exception flags from fpu_arithmetic_top
//  resp_valid     out  1      response present
//  resp_ready     in   1      consumer accepts
//  resp_data      out  32     result
//  resp_tag       out  TAG_W  tag of the request
//  resp_flags     out  5      {NV,DZ,OF,UF,NX} of this op
//  resp_err       out  1      1 = illegal rounding mode or timeout; resp_data = 0
//  csr_we         in   1      CSR write strobe
//  csr_wdata      in   8      {frm[2:0], fflags[4:0]}
//  csr_fflags     out  5      sticky fflags
//  csr_frm        out  3      dynamic rounding mode
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; fflags=0; frm=0; timer=0.
//  States and transitions:
//   - IDLE: req_ready=1. On req_valid, latch op/rm/a/b/tag/rs2_lsb.
//     - If the rm check fails: go to RESP with resp_err=1 and resp_flags=0.
//     - Otherwise: go to EXEC.
//   - rm check applies only to ops 00000/00001/00010/00011/01011/11000/11010.
//     It fails when rm is 101 or 110, or when rm=111 and frm is 101, 110 or 111.
//   - EXEC: fpu_start=1; operands held constant; timer increments each cycle.
//     - fpu_done=1: capture fpu_out and the 5 flags into resp_*; go to RESP.
//     - timer reaches TIMEOUT-1 without done: resp_err=1, flags=0, resp_data=0; go to RESP.
//     - fpu_start drops the cycle after leaving EXEC, which resets the mds handshake.
//   - RESP: resp_valid=1; resp_* stable until resp_ready.
//     - On resp_valid&resp_ready, go to IDLE.
//     - Back-to-back: req_ready=resp_ready in RESP. A same-cycle request is latched and goes directly to EXEC (or RESP if the rm check fails).
//  Latency: a combinational op is accepted in cycle N, is in EXEC in N+1, and has resp_valid in N+2.
//   Multi-cycle ops add (mds latency - 1) cycles.
//  Flush: any state goes to IDLE next cycle and start drops immediately. Captured/pending results are discarded and fflags are unchanged.
//   Flush has priority over every other event, including resp handshake and a new request.
//  fflags:
//   - fflags_next = (csr_we ? csr_wdata[4:0] : fflags) | (resp_fire ? resp_flags : 0).
//   - Accumulated on response handshake only, never on capture.
//   - frm_next = csr_we ? csr_wdata[7:5] : frm.
//   - A CSR write in EXEC does not alter fpu_frm for the in-flight op; frm is sampled at accept.
//  Errors never set fflags.
// STRUCTURE
//  Package fpu_ctrl_pkg: FPU op code constants, state encoding (IDLE/EXEC/RESP), flag bit indices NV=4..NX=0, and the rm legality function.
//  Sub-module fpu_csr_regs holds the fflags/frm registers and the write/accumulate rule. The rest is flat.
// TESTING
//  - FADD 1.0+2.0 (3F800000,40000000) rm=000 -> resp_data=40400000, flags=0, resp_valid at N+2.
//  - FDIV 1.0/0.0 -> resp_data=7F800000, resp_flags=01000, and fflags=01000 only after resp_ready.
//  - rm=111 with frm=101 on FMUL -> no fpu_start pulse, resp_err=1, fflags unchanged.
//    The same with op FSGNJ (00100) is issued normally.
//  - fpu_done held low for TIMEOUT=8 -> resp_err=1 after exactly 8 EXEC cycles, then fpu_start=0.
//  - Flush during FSQRT EXEC and during RESP -> IDLE next cycle, no resp fire, fflags unchanged.
//    Reset asserted mid-EXEC -> all outputs 0 asynchronously.
//  - csr_we wdata=8'h00 in the same cycle as a resp fire with NX -> fflags=00001.
//    Back-to-back requests with resp_ready=1 -> one response per 2 cycles.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types and constants for the FPU issue controller: op codes, state encoding,
// flag bit positions and the rounding-mode legality rule.
package fpu_ctrl_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned RM_W   = 3;
   localparam int unsigned FLAG_W = 5;
   localparam int unsigned CSR_W  = RM_W + FLAG_W;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   localparam logic [OP_W-1:0] OP_FADD     = 5'b00000;
   localparam logic [OP_W-1:0] OP_FSUB     = 5'b00001;
   localparam logic [OP_W-1:0] OP_FMUL     = 5'b00010;
   localparam logic [OP_W-1:0] OP_FDIV     = 5'b00011;
   localparam logic [OP_W-1:0] OP_FSGNJ    = 5'b00100;
   localparam logic [OP_W-1:0] OP_FSQRT    = 5'b01011;
   localparam logic [OP_W-1:0] OP_FCVT_W_S = 5'b11000;
   localparam logic [OP_W-1:0] OP_FCVT_S_W = 5'b11010;

   localparam logic [RM_W-1:0] RM_RSV5 = 3'b101;
   localparam logic [RM_W-1:0] RM_RSV6 = 3'b110;
   localparam logic [RM_W-1:0] RM_DYN  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [RM_W-1:0] rm;
      logic            rs2_lsb;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } fpu_cmd_t;

   // Only rounding ops care; dynamic rm is resolved through frm before the check.
   function automatic logic rm_illegal(input logic [OP_W-1:0] op,
                                       input logic [RM_W-1:0] rm,
                                       input logic [RM_W-1:0] frm);
      logic rm_op;
      rm_op = op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_FCVT_W_S, OP_FCVT_S_W};
      return rm_op && ((rm == RM_RSV5) || (rm == RM_RSV6) ||
                       ((rm == RM_DYN) && (frm inside {RM_RSV5, RM_RSV6, RM_DYN})));
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response, FPU-side and CSR signals of the FPU issue controller.
// slave = the controller, master = core pipeline plus arithmetic unit.
interface fpu_issue_ctrl_if #(parameter int unsigned TAG_W = 5);
   import fpu_ctrl_pkg::*;

   logic                 flush;
   logic                 req_valid;
   logic                 req_ready;
   logic [OP_W-1:0]      req_op;
   logic [RM_W-1:0]      req_rm;
   logic                 req_rs2_lsb;
   logic [XLEN-1:0]      req_a;
   logic [XLEN-1:0]      req_b;
   logic [TAG_W-1:0]     req_tag;
   logic                 fpu_start;
   logic [OP_W-1:0]      fpu_op;
   logic [RM_W-1:0]      fpu_rm;
   logic [RM_W-1:0]      fpu_frm;
   logic [XLEN-1:0]      fpu_a;
   logic [XLEN-1:0]      fpu_b;
   logic                 fpu_rs2_lsb;
   logic [XLEN-1:0]      fpu_out;
   logic                 fpu_done;
   logic                 fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [XLEN-1:0]      resp_data;
   logic [TAG_W-1:0]     resp_tag;
   logic [FLAG_W-1:0]    resp_flags;
   logic                 resp_err;
   logic                 csr_we;
   logic [CSR_W-1:0]     csr_wdata;
   logic [FLAG_W-1:0]    csr_fflags;
   logic [RM_W-1:0]      csr_frm;
   logic                 busy;

   modport slave (
      input  flush, req_valid, req_op, req_rm, req_rs2_lsb, req_a, req_b, req_tag,
             fpu_out, fpu_done, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
             resp_ready, csr_we, csr_wdata,
      output req_ready, fpu_start, fpu_op, fpu_rm, fpu_frm, fpu_a, fpu_b, fpu_rs2_lsb,
             resp_valid, resp_data, resp_tag, resp_flags, resp_err,
             csr_fflags, csr_frm, busy
   );

   modport master (
      output flush, req_valid, req_op, req_rm, req_rs2_lsb, req_a, req_b, req_tag,
             fpu_out, fpu_done, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
             resp_ready, csr_we, csr_wdata,
      input  req_ready, fpu_start, fpu_op, fpu_rm, fpu_frm, fpu_a, fpu_b, fpu_rs2_lsb,
             resp_valid, resp_data, resp_tag, resp_flags, resp_err,
             csr_fflags, csr_frm, busy
   );

endinterface

// File: rtl/fpu_issue_ctrl_csr_regs.sv
// Architectural fflags/frm state: CSR writes replace, response handshakes OR in flags.
module fpu_csr_regs
   import fpu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              csr_we,
   input  logic [CSR_W-1:0]  csr_wdata,
   input  logic              acc_en,
   input  logic [FLAG_W-1:0] acc_flags,
   output logic [FLAG_W-1:0] fflags,
   output logic [RM_W-1:0]   frm
);

   logic [FLAG_W-1:0] fflags_q, fflags_d;
   logic [RM_W-1:0]   frm_q, frm_d;

   always_comb begin
      fflags_d = (csr_we ? csr_wdata[FLAG_W-1:0] : fflags_q) | (acc_en ? acc_flags : '0);
      frm_d    = csr_we ? csr_wdata[CSR_W-1:FLAG_W] : frm_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fflags_q <= '0;
         frm_q    <= '0;
      end else begin
         fflags_q <= fflags_d;
         frm_q    <= frm_d;
      end
   end

   assign fflags = fflags_q;
   assign frm    = frm_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequencer between the FP pipeline and fpu_arithmetic_top: accepts one request,
// holds operands through execution, returns result/flags, owns fflags/frm.
module fpu_issue_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned TIMEOUT = 64
)(
   input  logic             clk,
   input  logic             reset,
   fpu_issue_ctrl_if.slave  io
);

   localparam int unsigned     TMR_W    = $clog2(TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   fpu_cmd_t           cmd_q, cmd_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [RM_W-1:0]    frm_snap_q, frm_snap_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               start_q, start_d;
   logic               idle_q, idle_d;
   logic               busy_q, busy_d;
   logic               resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]    resp_data_q, resp_data_d;
   logic [FLAG_W-1:0]  resp_flags_q, resp_flags_d;
   logic               resp_err_q, resp_err_d;
   logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
   logic [FLAG_W-1:0]  csr_fflags;
   logic [RM_W-1:0]    csr_frm;
   logic               req_fire, resp_fire, req_bad;

   // Flush wins over both handshakes; in RESP a new request rides on the response fire.
   assign resp_fire    = resp_valid_q & io.resp_ready & ~io.flush;
   assign io.req_ready = ~io.flush & (idle_q | (resp_valid_q & io.resp_ready));
   assign req_fire     = io.req_valid & io.req_ready;
   assign req_bad      = rm_illegal(io.req_op, io.req_rm, csr_frm);

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      tag_d        = tag_q;
      frm_snap_d   = frm_snap_q;
      timer_d      = timer_q;
      resp_data_d  = resp_data_q;
      resp_flags_d = resp_flags_q;
      resp_err_d   = resp_err_q;
      resp_tag_d   = resp_tag_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (resp_fire) state_d = ST_IDLE;
            if (req_fire) begin
               cmd_d.op      = io.req_op;
               cmd_d.rm      = io.req_rm;
               cmd_d.rs2_lsb = io.req_rs2_lsb;
               cmd_d.a       = io.req_a;
               cmd_d.b       = io.req_b;
               tag_d         = io.req_tag;
               frm_snap_d    = csr_frm;
               timer_d       = '0;
               if (req_bad) begin
                  state_d      = ST_RESP;
                  resp_data_d  = '0;
                  resp_flags_d = '0;
                  resp_err_d   = 1'b1;
                  resp_tag_d   = io.req_tag;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            timer_d = timer_q + TMR_W'(1);
            if (io.fpu_done) begin
               state_d               = ST_RESP;
               resp_data_d           = io.fpu_out;
               resp_flags_d[FLAG_NV] = io.fpu_nv;
               resp_flags_d[FLAG_DZ] = io.fpu_dz;
               resp_flags_d[FLAG_OF] = io.fpu_of;
               resp_flags_d[FLAG_UF] = io.fpu_uf;
               resp_flags_d[FLAG_NX] = io.fpu_nx;
               resp_err_d            = 1'b0;
               resp_tag_d            = tag_q;
            end else if (timer_q == TMR_LAST) begin
               state_d      = ST_RESP;
               resp_data_d  = '0;
               resp_flags_d = '0;
               resp_err_d   = 1'b1;
               resp_tag_d   = tag_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (io.flush) state_d = ST_IDLE;
      start_d      = (state_d == ST_EXEC);
      resp_valid_d = (state_d == ST_RESP);
      idle_d       = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         tag_q        <= '0;
         frm_snap_q   <= '0;
         timer_q      <= '0;
         start_q      <= 1'b0;
         idle_q       <= 1'b0;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_flags_q <= '0;
         resp_err_q   <= 1'b0;
         resp_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         tag_q        <= tag_d;
         frm_snap_q   <= frm_snap_d;
         timer_q      <= timer_d;
         start_q      <= start_d;
         idle_q       <= idle_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_flags_q <= resp_flags_d;
         resp_err_q   <= resp_err_d;
         resp_tag_q   <= resp_tag_d;
      end
   end

   fpu_csr_regs u_csr (
      .clk       (clk),
      .reset     (reset),
      .csr_we    (io.csr_we),
      .csr_wdata (io.csr_wdata),
      .acc_en    (resp_fire),
      .acc_flags (resp_flags_q),
      .fflags    (csr_fflags),
      .frm       (csr_frm)
   );

   assign io.fpu_start   = start_q;
   assign io.fpu_op      = cmd_q.op;
   assign io.fpu_rm      = cmd_q.rm;
   assign io.fpu_rs2_lsb = cmd_q.rs2_lsb;
   assign io.fpu_a       = cmd_q.a;
   assign io.fpu_b       = cmd_q.b;
   assign io.fpu_frm     = frm_snap_q;
   assign io.resp_valid  = resp_valid_q;
   assign io.resp_data   = resp_data_q;
   assign io.resp_flags  = resp_flags_q;
   assign io.resp_err    = resp_err_q;
   assign io.resp_tag    = resp_tag_q;
   assign io.csr_fflags  = csr_fflags;
   assign io.csr_frm     = csr_frm;
   assign io.busy        = busy_q;

endmodule
